shifter_operand_stage: RTL and testbench
========================================

SHIFTER_OPERAND_STAGE -- requirements
Module: shifter_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-004 SHALL have port in_valid, input, 1, upstream offers instr_in/rm_in this cycle.
REQ-005 SHALL have port in_ready, output, 1, stage accepts an offer this cycle.
REQ-006 SHALL have port instr_in, input, 32, fetched instruction word.
REQ-007 SHALL have port rm_in, input, 32, register-file value of Rm for instr_in.
REQ-008 SHALL have port out_valid, output, 1, head entry presented to the shifter.
REQ-009 SHALL have port out_ready, input, 1, downstream shifter/ALU consumes head this cycle.
REQ-010 SHALL have port rm_out, input-to-shifter, output, 32, Rm of head entry.
REQ-011 SHALL have port shifter_operand_out, output, 12, instr[11:0] of head entry.
REQ-012 SHALL have port type_out, output, 3, addressing-mode code of head entry.
REQ-013 SHALL have port undef_out, output, 1, head entry is an unsupported encoding.

Function
REQ-014 SHALL decode type from instr[27:25] and instr[4]: 000 with bit4=0 -> 000 (DP shift by immediate); 001 -> 001 (DP immediate); 010 -> 010 (LS immediate offset); 011 with bit4=0 -> 011 (LS register offset); 101 -> 100 (branch, pass-through).
REQ-015 SHALL, for every other encoding (incl. 000/011 with bit4=1), set type 111 and undef=1; otherwise undef=0.
REQ-016 SHALL store per entry {rm, instr[11:0], type, undef} = 48 bits, captured at acceptance.
REQ-017 SHALL be a 2-entry skid buffer with states EMPTY, ONE, FULL.
REQ-018 SHALL drive in_ready=1 in EMPTY and ONE, in_ready=0 in FULL (registered, not combinational on out_ready).
REQ-019 SHALL drive out_valid=1 in ONE and FULL, 0 in EMPTY; outputs always show the oldest entry.
REQ-020 SHALL define accept = in_valid & in_ready, consume = out_valid & out_ready.
REQ-021 SHALL transition: EMPTY+accept -> ONE; ONE+accept+!consume -> FULL; ONE+!accept+consume -> EMPTY; ONE+accept+consume -> ONE (new entry becomes head); FULL+consume -> ONE (second entry becomes head); otherwise hold.
REQ-022 SHALL give latency 1: an entry accepted at edge N is on outputs with out_valid=1 after edge N.
REQ-023 SHALL hold all head outputs stable while out_valid=1 and out_ready=0.
REQ-024 SHALL preserve FIFO order; no entry dropped or duplicated except by flush/reset.
REQ-025 SHALL, on flush=1, go to EMPTY at that edge, ignoring simultaneous accept and consume.
REQ-026 SHALL force rm_out, shifter_operand_out, type_out, undef_out to 0 whenever out_valid=0.

Reset
REQ-027 SHALL, with reset_n=0 at a rising edge, enter EMPTY and clear both entries; reset overrides flush, accept, consume.
REQ-028 SHALL present after reset: out_valid=0, in_ready=1, rm_out=0, shifter_operand_out=0, type_out=000, undef_out=0.
REQ-029 SHALL treat reset asserted mid-transfer identically: all buffered entries lost, no output pulse.

Verification
REQ-030 SHALL verify decode: instr_in=32'hE1A00387, rm_in=32'hEB000007, out_ready=1 -> next cycle type_out=000, shifter_operand_out=12'h387, rm_out=32'hEB000007, undef_out=0; instr_in=32'hE3A00387 -> type_out=001.
REQ-031 SHALL verify LS/branch/undef: instr[27:25]=010 -> 010; 011 with bit4=0 (12'h5C5) -> 011; 101 -> 100; 011 with bit4=1 -> type_out=111, undef_out=1.
REQ-032 SHALL verify backpressure: out_ready=0, offer A then B -> in_ready=0 after second edge, head=A stable; raise out_ready -> A, B emerge in order, in_ready=1 again.
REQ-033 SHALL verify streaming: in_valid=1, out_ready=1 for 8 cycles, distinct rm_in 1..8 -> rm_out 1..8 on consecutive cycles, state stays ONE.
REQ-034 SHALL verify flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, outputs 0.
REQ-035 SHALL verify reset: FULL state, reset_n=0 one edge -> values of REQ-028; assert reset_n=0 with flush=0 and in_valid=1 -> nothing accepted.

Source files
------------

// File: rtl/shifter_operand_stage_if.sv
// Handshake and data bundle between the fetch/register-read side, the operand
// stage and the downstream shifter/ALU.
interface shifter_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] rm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rm_out;
    logic [11:0] shifter_operand_out;
    logic [2:0]  type_out;
    logic        undef_out;

    modport master (
        output in_valid, instr_in, rm_in, out_ready,
        input  in_ready, out_valid, rm_out, shifter_operand_out, type_out, undef_out
    );

    modport slave (
        input  in_valid, instr_in, rm_in, out_ready,
        output in_ready, out_valid, rm_out, shifter_operand_out, type_out, undef_out
    );
endinterface

// File: rtl/shifter_operand_stage.sv
// Operand stage in front of the barrel shifter: decodes the addressing-mode
// type of each instruction and holds up to two entries in a skid buffer.
module shifter_operand_stage (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    shifter_operand_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [31:0] rm;
        logic [11:0] operand;
        logic [2:0]  kind;
        logic        undef;
    } entry_t;

    // Returns {type, undef}; anything not explicitly supported maps to 111/undef.
    function automatic logic [3:0] decode_type(input logic [31:0] instr);
        logic [3:0] res;
        case (instr[27:25])
            3'b000: begin
                if (instr[4] == 1'b0) res = 4'b0000;
                else                  res = 4'b1111;
            end
            3'b001: res = 4'b0010;
            3'b010: res = 4'b0100;
            3'b011: begin
                if (instr[4] == 1'b0) res = 4'b0110;
                else                  res = 4'b1111;
            end
            3'b101: res = 4'b1000;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    entry_t     head_r;
    entry_t     tail_r;
    entry_t     head_nxt_s;
    entry_t     tail_nxt_s;
    entry_t     new_entry_s;
    logic [3:0] decoded_s;
    logic       in_ready_s;
    logic       out_valid_s;
    logic       accept_s;
    logic       consume_s;

    // Build the entry that would be captured if the current offer is accepted.
    always_comb begin
        decoded_s   = decode_type(bus.instr_in);
        new_entry_s = '{rm: bus.rm_in, operand: bus.instr_in[11:0],
                        kind: decoded_s[3:1], undef: decoded_s[0]};
        accept_s    = bus.in_valid & in_ready_s;
        consume_s   = out_valid_s & bus.out_ready;
    end

    // State and entry registers; reset wins over everything, then flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_EMPTY;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
        end
    end

    // Next-state and next-entry logic; the head is zeroed whenever it empties.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            head_nxt_s  = '0;
            tail_nxt_s  = '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_ONE;
                        head_nxt_s  = new_entry_s;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !consume_s) begin
                        state_nxt_s = ST_FULL;
                        tail_nxt_s  = new_entry_s;
                    end else if (accept_s && consume_s) begin
                        state_nxt_s = ST_ONE;
                        head_nxt_s  = new_entry_s;
                    end else if (consume_s) begin
                        state_nxt_s = ST_EMPTY;
                        head_nxt_s  = '0;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (consume_s) begin
                        state_nxt_s = ST_ONE;
                        head_nxt_s  = tail_r;
                        tail_nxt_s  = '0;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    head_nxt_s  = '0;
                    tail_nxt_s  = '0;
                end
            endcase
        end
    end

    // Handshake flags come only from the state register; head fields are gated.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            ST_ONE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b1;
            end
            ST_FULL: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
        bus.in_ready  = in_ready_s;
        bus.out_valid = out_valid_s;
        if (out_valid_s) begin
            bus.rm_out              = head_r.rm;
            bus.shifter_operand_out = head_r.operand;
            bus.type_out            = head_r.kind;
            bus.undef_out           = head_r.undef;
        end else begin
            bus.rm_out              = 32'd0;
            bus.shifter_operand_out = 12'd0;
            bus.type_out            = 3'd0;
            bus.undef_out           = 1'b0;
        end
    end

endmodule

// File: tb/tb_shifter_operand_stage.sv
// Scoreboard bench for shifter_operand_stage: expected entries are queued on
// acceptance and compared against the head every cycle.
module tb_shifter_operand_stage;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;

    always #5 clk = ~clk;

    shifter_operand_stage_if bus ();

    shifter_operand_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] rm;
        logic [11:0] op;
        logic [2:0]  kind;
        logic        undef;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] cur_type;
    logic       cur_undef;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare the DUT against the model, update the model, advance one clock.
    task automatic step();
        exp_t e;
        bit   m_valid;
        bit   m_ready;
        bit   acc;
        bit   con;
        m_valid = (sb_q.size() > 0);
        m_ready = (sb_q.size() < 2);
        e       = m_valid ? sb_q[0] : '0;
        check("in_ready",  64'(bus.in_ready),            64'(m_ready));
        check("out_valid", 64'(bus.out_valid),           64'(m_valid));
        check("rm_out",    64'(bus.rm_out),              64'(e.rm));
        check("operand",   64'(bus.shifter_operand_out), 64'(e.op));
        check("type_out",  64'(bus.type_out),            64'(e.kind));
        check("undef_out", 64'(bus.undef_out),           64'(e.undef));
        acc = bus.in_valid && m_ready;
        con = m_valid && bus.out_ready;
        if (!reset_n || flush) begin
            sb_q.delete();
        end else begin
            if (con) void'(sb_q.pop_front());
            if (acc) sb_q.push_back({bus.rm_in, bus.instr_in[11:0], cur_type, cur_undef});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rm,
                         input logic [2:0] t, input logic u);
        bus.in_valid = 1'b1;
        bus.instr_in = instr;
        bus.rm_in    = rm;
        cur_type     = t;
        cur_undef    = u;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.instr_in = 32'd0;
        bus.rm_in    = 32'd0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rm;
        logic [2:0]  t;
        logic        u;
    } vec_t;

    vec_t dec_tab[10];

    initial begin
        dec_tab[0] = '{32'hE1A00387, 32'hEB000007, 3'b000, 1'b0};
        dec_tab[1] = '{32'hE3A00387, 32'h00000011, 3'b001, 1'b0};
        dec_tab[2] = '{32'hE5912004, 32'h00000022, 3'b010, 1'b0};
        dec_tab[3] = '{32'hE79125C5, 32'h00000033, 3'b011, 1'b0};
        dec_tab[4] = '{32'hEA000010, 32'h00000044, 3'b100, 1'b0};
        dec_tab[5] = '{32'hE7912015, 32'h00000055, 3'b111, 1'b1};
        dec_tab[6] = '{32'hE1A00317, 32'h00000066, 3'b111, 1'b1};
        dec_tab[7] = '{32'hE9000000, 32'h00000077, 3'b111, 1'b1};
        dec_tab[8] = '{32'hEE000000, 32'h00000088, 3'b111, 1'b1};
        dec_tab[9] = '{32'hEC000000, 32'h00000099, 3'b111, 1'b1};

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        cur_type      = 3'd0;
        cur_undef     = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step();                       // still in reset: reset values
        reset_n = 1'b1;
        step();

        // Decode table, streamed back to back
        foreach (dec_tab[i]) begin
            drive(dec_tab[i].instr, dec_tab[i].rm, dec_tab[i].t, dec_tab[i].u);
            step();
        end
        idle();
        step();
        step();

        // Backpressure: A then B fill the buffer, C is refused while full
        bus.out_ready = 1'b0;
        drive(32'hE1A00001, 32'hAAAA0001, 3'b000, 1'b0);
        step();
        drive(32'hE3A00002, 32'hBBBB0002, 3'b001, 1'b0);
        step();
        drive(32'hE5900003, 32'hCCCC0003, 3'b010, 1'b0);
        step();
        step();
        idle();
        step();
        bus.out_ready = 1'b1;
        step();
        step();
        step();

        // Streaming: one in, one out every cycle
        for (int i = 1; i <= 8; i++) begin
            drive(32'hE1A00100 + 32'(i), 32'(i), 3'b000, 1'b0);
            step();
        end
        idle();
        step();
        step();

        // Flush from FULL with a simultaneous offer
        bus.out_ready = 1'b0;
        drive(32'hE3A00011, 32'h11111111, 3'b001, 1'b0);
        step();
        drive(32'hE3A00022, 32'h22222222, 3'b001, 1'b0);
        step();
        flush = 1'b1;
        drive(32'hE3A00033, 32'h33333333, 3'b001, 1'b0);
        step();
        flush = 1'b0;
        idle();
        step();

        // Flush from ONE with simultaneous accept and consume
        bus.out_ready = 1'b1;
        drive(32'hE5900044, 32'h44444444, 3'b010, 1'b0);
        step();
        flush = 1'b1;
        drive(32'hE5900055, 32'h55555555, 3'b010, 1'b0);
        step();
        flush = 1'b0;
        idle();
        step();

        // Reset from FULL with an offer held during reset
        bus.out_ready = 1'b0;
        drive(32'hEA000066, 32'h66666666, 3'b100, 1'b0);
        step();
        drive(32'hEA000077, 32'h77777777, 3'b100, 1'b0);
        step();
        reset_n = 1'b0;
        drive(32'hEA000088, 32'h88888888, 3'b100, 1'b0);
        step();
        step();
        reset_n = 1'b1;
        idle();
        bus.out_ready = 1'b1;
        step();
        step();

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
